// File: rtl/nco_pkg.sv
// Shared types, latency and table generator for the quarter-wave sin/cos NCO.
package nco_pkg;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quadrant_e;

   // Request-to-sample latency in clock cycles.
   localparam int NCO_LAT = 3;

   // pi scaled by 2^60 (leading hex digits of pi).
   localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

   // Quarter-wave table entry:
   //   round((2^(amp_w-1)-1) * sin(pi*(2k+1)/2^phase_w))
   // Evaluated with a 2^60 fixed-point Taylor series so it folds to a constant.
   // Every partial sum stays positive over (0, pi/2], so unsigned math is safe.
   function automatic logic [63:0] nco_table_entry(input int k, input int phase_w,
                                                   input int amp_w);
      logic [127:0] x;
      logic [127:0] x2;
      logic [127:0] term;
      logic [127:0] sum;
      logic [127:0] amp;
      logic [127:0] r;
      x    = (128'(PI_Q60) * 128'(2 * k + 1)) >> phase_w;
      x2   = (x * x) >> 60;
      term = x;
      sum  = x;
      for (int n = 1; n <= 20; n++) begin
         term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
         if ((n % 2) == 1) sum = sum - term;
         else              sum = sum + term;
      end
      amp = (128'(1) << (amp_w - 1)) - 128'(1);
      r   = (sum * amp + (128'(1) << 59)) >> 60;
      return r[63:0];
   endfunction

endpackage

// File: rtl/sincos_qw_rom.sv
// Dual-read-port quarter-wave magnitude ROM, registered outputs (1-cycle latency).
module sincos_qw_rom
   import nco_pkg::*;
#(
   parameter int PHASE_W = 12,
   parameter int AMP_W   = 16
) (
   input  logic               iclk,
   input  logic               iresetn,
   input  logic [PHASE_W-3:0] iaddr_a,
   input  logic [PHASE_W-3:0] iaddr_b,
   output logic [AMP_W-2:0]   odata_a,
   output logic [AMP_W-2:0]   odata_b
);

   localparam int N = 2 ** (PHASE_W - 2);

   logic [AMP_W-2:0] rom_w [N];
   logic [AMP_W-2:0] data_a_q;
   logic [AMP_W-2:0] data_b_q;

   // Constant table contents, one elaboration-time entry per address.
   for (genvar g = 0; g < N; g++) begin : g_rom
      localparam logic [63:0] ENTRY = nco_table_entry(g, PHASE_W, AMP_W);
      assign rom_w[g] = ENTRY[AMP_W-2:0];
   end

   // Synchronous read of both ports.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         data_a_q <= '0;
         data_b_q <= '0;
      end else begin
         data_a_q <= rom_w[iaddr_a];
         data_b_q <= rom_w[iaddr_b];
      end
   end

   assign odata_a = data_a_q;
   assign odata_b = data_b_q;

endmodule

// File: rtl/nco_sincos_qw.sv
// NCO: phase accumulator + phase offset + quarter-wave folded sin/cos, 3-stage pipe.
// Interface: iv is a one-cycle sample request with no backpressure; ov pulses
// exactly NCO_LAT cycles after each accepted iv, and outputs hold while ov=0.
module nco_sincos_qw
   import nco_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int PHASE_W = 12,
   parameter int AMP_W   = 16
) (
   input  logic               iclk,
   input  logic               iresetn,
   input  logic               iv,
   input  logic [ACC_W-1:0]   ifreq,
   input  logic [PHASE_W-1:0] iphoff,
   input  logic               isync,
   output logic               ov,
   output logic [PHASE_W-1:0] ophase,
   output logic [AMP_W-1:0]   osin,
   output logic [AMP_W-1:0]   ocos
);

   localparam int KW = PHASE_W - 2;

   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [PHASE_W-1:0] base_phase_d, p_d;
   quadrant_e          q_d;
   logic [KW-1:0]      k_d, addr_sin_d, addr_cos_d;

   logic               v1_q;
   logic [PHASE_W-1:0] p1_q;
   quadrant_e          q1_q;
   logic [KW-1:0]      addr_sin_q, addr_cos_q;

   logic               v2_q;
   logic [PHASE_W-1:0] p2_q;
   logic               sin_neg_q, cos_neg_q;
   logic [AMP_W-2:0]   rom_sin, rom_cos;

   logic [AMP_W-1:0]   sin_mag_d, cos_mag_d, sin_d, cos_d;
   logic               ov_q;
   logic [PHASE_W-1:0] ophase_q;
   logic [AMP_W-1:0]   osin_q, ocos_q;

   // Phase generation and quadrant folding into the two ROM addresses.
   always_comb begin
      base_phase_d = isync ? '0 : acc_q[ACC_W-1 -: PHASE_W];
      p_d          = base_phase_d + iphoff;
      acc_d        = isync ? ifreq : acc_q + ifreq;
      q_d          = quadrant_e'(p_d[PHASE_W-1 -: 2]);
      k_d          = p_d[KW-1:0];
      addr_sin_d   = k_d;
      addr_cos_d   = ~k_d;
      case (q_d)
         Q1, Q3: begin
            addr_sin_d = ~k_d;
            addr_cos_d = k_d;
         end
         default: begin
            addr_sin_d = k_d;
            addr_cos_d = ~k_d;
         end
      endcase
   end

   // Accumulator advances only on accepted requests.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) acc_q <= '0;
      else if (iv)  acc_q <= acc_d;
   end

   // Stage 1: phase, quadrant and ROM addresses.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         v1_q       <= 1'b0;
         p1_q       <= '0;
         q1_q       <= Q0;
         addr_sin_q <= '0;
         addr_cos_q <= '0;
      end else begin
         v1_q <= iv;
         if (iv) begin
            p1_q       <= p_d;
            q1_q       <= q_d;
            addr_sin_q <= addr_sin_d;
            addr_cos_q <= addr_cos_d;
         end
      end
   end

   sincos_qw_rom #(
      .PHASE_W(PHASE_W),
      .AMP_W  (AMP_W)
   ) u_rom (
      .iclk   (iclk),
      .iresetn(iresetn),
      .iaddr_a(addr_sin_q),
      .iaddr_b(addr_cos_q),
      .odata_a(rom_sin),
      .odata_b(rom_cos)
   );

   // Stage 2: sign flags travel alongside the ROM read.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         v2_q      <= 1'b0;
         p2_q      <= '0;
         sin_neg_q <= 1'b0;
         cos_neg_q <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            p2_q      <= p1_q;
            sin_neg_q <= (q1_q == Q2) || (q1_q == Q3);
            cos_neg_q <= (q1_q == Q1) || (q1_q == Q2);
         end
      end
   end

   // Sign application; magnitudes never reach -2^(AMP_W-1), so negation is safe.
   always_comb begin
      sin_mag_d = {1'b0, rom_sin};
      cos_mag_d = {1'b0, rom_cos};
      sin_d     = sin_neg_q ? (~sin_mag_d + 1'b1) : sin_mag_d;
      cos_d     = cos_neg_q ? (~cos_mag_d + 1'b1) : cos_mag_d;
   end

   // Stage 3: output registers, held between valid samples.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         ov_q     <= 1'b0;
         ophase_q <= '0;
         osin_q   <= '0;
         ocos_q   <= '0;
      end else begin
         ov_q <= v2_q;
         if (v2_q) begin
            ophase_q <= p2_q;
            osin_q   <= sin_d;
            ocos_q   <= cos_d;
         end
      end
   end

   assign ov     = ov_q;
   assign ophase = ophase_q;
   assign osin   = osin_q;
   assign ocos   = ocos_q;

endmodule

// File: tb/tb_nco_sincos_qw.sv
// Bench for nco_sincos_qw: real-math reference model, expected queue, decoupled monitor.
module tb_nco_sincos_qw;
   import nco_pkg::*;

   localparam int  ACC_W   = 32;
   localparam int  PHASE_W = 12;
   localparam int  AMP_W   = 16;
   localparam int  W       = 32 + PHASE_W + 2 * AMP_W;
   localparam real PI      = 3.14159265358979323846;
   localparam real PEAK    = 32767.0;

   // ---------------- clock / reset ----------------
   logic               iclk    = 1'b0;
   logic               iresetn = 1'b0;
   logic               iv      = 1'b0;
   logic               isync   = 1'b0;
   logic [ACC_W-1:0]   ifreq   = '0;
   logic [PHASE_W-1:0] iphoff  = '0;
   logic               ov;
   logic [PHASE_W-1:0] ophase;
   logic [AMP_W-1:0]   osin;
   logic [AMP_W-1:0]   ocos;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W-1:0]     exp_q[$];
   logic [ACC_W-1:0] m_acc = '0;

   nco_sincos_qw #(
      .ACC_W  (ACC_W),
      .PHASE_W(PHASE_W),
      .AMP_W  (AMP_W)
   ) dut (
      .iclk   (iclk),
      .iresetn(iresetn),
      .iv     (iv),
      .ifreq  (ifreq),
      .iphoff (iphoff),
      .isync  (isync),
      .ov     (ov),
      .ophase (ophase),
      .osin   (osin),
      .ocos   (ocos)
   );

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic int ref_amp(input int p, input bit is_cos);
      real th;
      real v;
      th = 2.0 * PI * (real'(p) + 0.5) / real'(1 << PHASE_W);
      v  = PEAK * (is_cos ? $cos(th) : $sin(th));
      if (v >= 0.0) return $rtoi(v + 0.5);
      else          return -$rtoi(-v + 0.5);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input logic v, input logic [ACC_W-1:0] f,
                        input logic [PHASE_W-1:0] off, input logic s);
      logic [ACC_W-1:0] a;
      int p;
      iv     = v;
      ifreq  = f;
      iphoff = off;
      isync  = s;
      if (v) begin
         a     = s ? '0 : m_acc;
         p     = (int'(a >> (ACC_W - PHASE_W)) + int'(off)) % (1 << PHASE_W);
         m_acc = s ? f : m_acc + f;
         exp_q.push_back({32'(cyc + NCO_LAT), PHASE_W'(p),
                          AMP_W'(ref_amp(p, 1'b0)), AMP_W'(ref_amp(p, 1'b1))});
      end
      @(posedge iclk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, '0, '0, 1'b0);
   endtask

   task automatic check(input string name, input logic signed [63:0] got,
                        input logic signed [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge iclk) begin
      logic [W-1:0] e;
      int           e_cyc;
      longint       pw;
      if (iresetn) begin
         if (ov) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ov at cycle %0d ophase=%0d", cyc, ophase);
            end else begin
               e     = exp_q.pop_front();
               e_cyc = int'(e[W-1 -: 32]);
               if (e_cyc != cyc || ophase !== e[2*AMP_W +: PHASE_W] ||
                   osin !== e[AMP_W +: AMP_W] || ocos !== e[0 +: AMP_W]) begin
                  bad++;
                  $display("FAIL sample got cyc=%0d ph=%0d sin=%0d cos=%0d want cyc=%0d ph=%0d sin=%0d cos=%0d",
                           cyc, ophase, $signed(osin), $signed(ocos), e_cyc,
                           e[2*AMP_W +: PHASE_W], $signed(e[AMP_W +: AMP_W]),
                           $signed(e[0 +: AMP_W]));
               end
               pw = longint'($signed(osin)) * longint'($signed(osin)) +
                    longint'($signed(ocos)) * longint'($signed(ocos));
               total++;
               if (pw > 64'sd1073676289 + 64'sd65536 || pw < 64'sd1073676289 - 64'sd65536) begin
                  bad++;
                  $display("FAIL power got=%0d want=%0d (+-65536)", pw, 64'sd1073676289);
               end
            end
         end else if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) <= cyc) begin
            total++;
            bad++;
            $display("FAIL missing_ov got ov=0 at cycle %0d want ov=1", cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      iresetn = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      check("reset_ov", 64'(ov), 0);
      check("reset_ophase", 64'(ophase), 0);
      check("reset_osin", 64'(osin), 0);
      check("reset_ocos", 64'(ocos), 0);
      iresetn = 1'b1;
      @(posedge iclk);
      #1;

      // Quadrant corners with a stopped accumulator.
      issue(1'b1, '0, 12'd0, 1'b1);
      issue(1'b1, '0, 12'd1024, 1'b1);
      issue(1'b1, '0, 12'd2048, 1'b1);
      issue(1'b1, '0, 12'd3072, 1'b1);
      idle(4);

      // Full phase ramp, one table step per sample, wrapping back to 0.
      issue(1'b1, 32'h0010_0000, 12'd0, 1'b1);
      for (int i = 0; i < 4096; i++) issue(1'b1, 32'h0010_0000, 12'd0, 1'b0);
      idle(4);

      // Bubble pattern: accumulator advances only on requests.
      begin
         logic [5:0] pat;
         pat = 6'b011001;
         for (int i = 0; i < 6; i++) issue(pat[i], 32'h0010_0000, 12'd0, i == 0);
      end
      idle(4);

      // Negative frequency.
      issue(1'b1, 32'hFFF0_0000, 12'd0, 1'b1);
      for (int i = 0; i < 20; i++) issue(1'b1, 32'hFFF0_0000, 12'd0, 1'b0);
      idle(4);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         issue($urandom_range(0, 9) < 7, $urandom, PHASE_W'($urandom_range(0, 4095)),
               $urandom_range(0, 19) == 0);
      end
      idle(6);
      check("drain_empty", 64'(exp_q.size()), 0);

      // Reset with the output valid and two more samples in flight.
      issue(1'b1, 32'h0010_0000, 12'd100, 1'b1);
      for (int i = 0; i < 4; i++) issue(1'b1, 32'h0010_0000, 12'd100, 1'b0);
      iv = 1'b0;
      #2;
      iresetn = 1'b0;
      #1;
      check("midreset_ov", 64'(ov), 0);
      check("midreset_ophase", 64'(ophase), 0);
      check("midreset_osin", 64'(osin), 0);
      check("midreset_ocos", 64'(ocos), 0);
      exp_q.delete();
      m_acc = '0;
      repeat (2) @(posedge iclk);
      #1;
      iresetn = 1'b1;
      @(posedge iclk);
      #1;
      issue(1'b1, 32'h0010_0000, 12'd0, 1'b0);
      issue(1'b1, 32'h0010_0000, 12'd0, 1'b0);
      idle(6);
      check("final_empty", 64'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
